ramio_fifo: RTL and testbench

Parametrised successor of the CPU-side memory/I/O port. Sits between the CPU core and the cache: decodes memory-mapped I/O (LEDs, UART TX, UART RX, UART status), forwards all other accesses to the cache with byte-lane conversion, and buffers both UART directions in FIFOs so that software no longer drops received bytes or polls per transmitted byte.

---
 rtl/ramio_fifo.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_ramio_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramio_fifo.sv
// CPU-side memory/I/O port: decodes LED and UART registers, forwards other accesses
// to the cache with byte-lane conversion, and buffers both UART directions in FIFOs.

module uarttx #(
    parameter int ClockFrequencyHz = 20_250_000,
    parameter int BaudRate         = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] data,
    output logic       bsy,
    output logic       tx
);
    localparam int Div  = ClockFrequencyHz / BaudRate;
    localparam int DivW = $clog2(Div) + 1;

    logic            busy_q, tx_q, go_prev_q;
    logic [8:0]      shreg_q;
    logic [3:0]      bitn_q;
    logic [DivW-1:0] div_q;

    // A frame starts on the rising edge of go, so a go held high never retransmits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
            go_prev_q <= 1'b0;
            shreg_q   <= '1;
            bitn_q    <= '0;
            div_q     <= '0;
        end else begin
            go_prev_q <= go;
            if (!busy_q) begin
                if (go && !go_prev_q) begin
                    busy_q  <= 1'b1;
                    tx_q    <= 1'b0;
                    shreg_q <= {1'b1, data};
                    bitn_q  <= '0;
                    div_q   <= '0;
                end
            end else if (div_q == DivW'(Div - 1)) begin
                div_q <= '0;
                if (bitn_q == 4'd9) begin
                    busy_q <= 1'b0;
                end else begin
                    tx_q    <= shreg_q[0];
                    shreg_q <= {1'b1, shreg_q[8:1]};
                    bitn_q  <= bitn_q + 4'd1;
                end
            end else begin
                div_q <= div_q + DivW'(1);
            end
        end
    end

    assign bsy = busy_q;
    assign tx  = tx_q;
endmodule

module uartrx #(
    parameter int ClockFrequencyHz = 20_250_000,
    parameter int BaudRate         = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_ready
);
    localparam int Div  = ClockFrequencyHz / BaudRate;
    localparam int Half = Div / 2;
    localparam int DivW = $clog2(Div) + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e       state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [7:0]      shreg_q, shreg_d, data_q, data_d;
    logic            ready_q, ready_d;
    logic [1:0]      sync_q;
    logic            rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            div_q   <= '0;
            bitn_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bitn_q  <= bitn_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            sync_q  <= {sync_q[0], rx};
        end
    end

    // Bits are sampled mid-period; data_ready holds until the consumer drops go.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bitn_d  = bitn_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ready_d = go ? ready_q : 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    div_d   = '0;
                end
            end
            RX_START: begin
                if (div_q == DivW'(Half - 1)) begin
                    div_d   = '0;
                    bitn_d  = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            RX_DATA: begin
                if (div_q == DivW'(Div - 1)) begin
                    div_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) state_d = RX_STOP;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            RX_STOP: begin
                if (div_q == DivW'(Div - 1)) begin
                    state_d = RX_IDLE;
                    data_d  = shreg_q;
                    ready_d = 1'b1;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data       = data_q;
    assign data_ready = ready_q;
endmodule

module ramio_fifo_buf #(
    parameter int DepthLog2 = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [7:0]         wdata_i,
    input  logic               pop_i,
    output logic [7:0]         head_o,
    output logic [DepthLog2:0] count_o,
    output logic               empty_o,
    output logic               full_o
);
    localparam int Depth = 1 << DepthLog2;
    localparam int CntW  = DepthLog2 + 1;

    logic [7:0]           mem_q [Depth];
    logic [DepthLog2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 wr_ok, rd_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = count_q[DepthLog2];
    // A push into a full buffer succeeds when the same cycle pops a slot free.
    assign wr_ok   = push_i && (!full_o || pop_i);
    assign rd_ok   = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok)      count_d = count_q + CntW'(1);
        else if (rd_ok && !wr_ok) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + DepthLog2'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + DepthLog2'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

module ramio_fifo #(
    parameter int AddressBitWidth  = 32,
    parameter int DataBitWidth     = 32,
    parameter int ClockFrequencyHz = 20_250_000,
    parameter int BaudRate         = 9600,
    parameter int LedCount         = 6,
    parameter int RxFifoDepthLog2  = 4,
    parameter int TxFifoDepthLog2  = 4,
    parameter logic [AddressBitWidth-1:0] AddressLed        = 32'hffff_fffc,
    parameter logic [AddressBitWidth-1:0] AddressUartOut    = 32'hffff_fff8,
    parameter logic [AddressBitWidth-1:0] AddressUartIn     = 32'hffff_fff4,
    parameter logic [AddressBitWidth-1:0] AddressUartStatus = 32'hffff_fff0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [2:0]                 read_type,
    input  logic [1:0]                 write_type,
    input  logic [AddressBitWidth-1:0] address,
    input  logic [DataBitWidth-1:0]    data_in,
    output logic [DataBitWidth-1:0]    data_out,
    output logic                       data_out_ready,
    output logic                       busy,
    output logic [LedCount-1:0]        led,
    output logic                       uart_tx,
    input  logic                       uart_rx,
    output logic                       cache_enable,
    output logic [AddressBitWidth-1:0] cache_address,
    output logic [DataBitWidth-1:0]    cache_data_in,
    output logic [3:0]                 cache_write_enable,
    input  logic [DataBitWidth-1:0]    cache_data_out,
    input  logic                       cache_data_out_ready,
    input  logic                       cache_busy
);
    typedef enum logic [1:0] {TX_IDLE, TX_ARM, TX_SEND, TX_ACK} tx_state_e;

    tx_state_e           tx_state_q, tx_state_d;
    logic                tx_go_q, tx_go_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [LedCount-1:0] led_q, led_d;
    logic                overrun_q, overrun_d;
    logic                rx_go_q, rx_go_d;

    logic hit_led, hit_out, hit_in, hit_status, io_hit, is_read, is_write;
    logic tx_push, tx_pop, tx_empty, tx_full, tx_bsy, tx_idle;
    logic rx_push, rx_pop, rx_empty, rx_full, rx_ready, rx_overrun_evt, status_rd;
    logic [7:0]                 tx_head, rx_head, rx_byte;
    logic [TxFifoDepthLog2:0]   tx_count;
    logic [RxFifoDepthLog2:0]   rx_count;
    logic [DataBitWidth-1:0]    io_rdata, cache_rdata, lane_data;
    logic [1:0]                 lane;

    assign hit_led    = (address == AddressLed);
    assign hit_out    = (address == AddressUartOut);
    assign hit_in     = (address == AddressUartIn);
    assign hit_status = (address == AddressUartStatus);
    assign io_hit     = hit_led || hit_out || hit_in || hit_status;
    assign is_read    = (read_type[1:0] != 2'b00);
    assign is_write   = (write_type != 2'b00);
    assign lane       = address[1:0];

    assign tx_push        = enable && hit_out && is_write && !tx_full;
    assign rx_pop         = enable && hit_in && is_read && !rx_empty;
    assign status_rd      = enable && hit_status && is_read;
    assign rx_push        = rx_go_q && rx_ready;
    assign rx_overrun_evt = rx_push && rx_full && !rx_pop;
    assign tx_idle        = tx_empty && (tx_state_q == TX_IDLE);

    ramio_fifo_buf #(.DepthLog2(TxFifoDepthLog2)) u_tx_fifo (
        .clk(clk), .rst_i(rst), .push_i(tx_push), .wdata_i(data_in[7:0]), .pop_i(tx_pop),
        .head_o(tx_head), .count_o(tx_count), .empty_o(tx_empty), .full_o(tx_full)
    );

    ramio_fifo_buf #(.DepthLog2(RxFifoDepthLog2)) u_rx_fifo (
        .clk(clk), .rst_i(rst), .push_i(rx_push), .wdata_i(rx_byte), .pop_i(rx_pop),
        .head_o(rx_head), .count_o(rx_count), .empty_o(rx_empty), .full_o(rx_full)
    );

    uarttx #(.ClockFrequencyHz(ClockFrequencyHz), .BaudRate(BaudRate)) u_uarttx (
        .clk(clk), .rst_n(!rst), .go(tx_go_q), .data(tx_data_q), .bsy(tx_bsy), .tx(uart_tx)
    );

    uartrx #(.ClockFrequencyHz(ClockFrequencyHz), .BaudRate(BaudRate)) u_uartrx (
        .clk(clk), .rst_n(!rst), .go(rx_go_q), .rx(uart_rx), .data(rx_byte), .data_ready(rx_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_go_q    <= 1'b0;
            tx_data_q  <= '0;
            led_q      <= '1;
            overrun_q  <= 1'b0;
            rx_go_q    <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_go_q    <= tx_go_d;
            tx_data_q  <= tx_data_d;
            led_q      <= led_d;
            overrun_q  <= overrun_d;
            rx_go_q    <= rx_go_d;
        end
    end

    // TX engine: go is dropped in ACK so the transmitter sees a fresh rising edge per byte.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_go_d    = tx_go_q;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_head;
                    tx_go_d    = 1'b1;
                    tx_state_d = TX_ARM;
                end
            end
            TX_ARM:  tx_state_d = TX_SEND;
            TX_SEND: if (!tx_bsy) tx_state_d = TX_ACK;
            TX_ACK: begin
                tx_go_d    = 1'b0;
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // A new overrun in the same cycle as a status read keeps the flag set.
    always_comb begin
        led_d     = (enable && hit_led && is_write) ? data_in[LedCount-1:0] : led_q;
        overrun_d = rx_overrun_evt ? 1'b1 : (status_rd ? 1'b0 : overrun_q);
        rx_go_d   = !rx_push;
    end

    always_comb begin
        io_rdata = '0;
        if (hit_led) begin
            io_rdata = DataBitWidth'(led_q);
        end else if (hit_out) begin
            io_rdata = tx_idle ? '1 : DataBitWidth'(tx_count);
        end else if (hit_in) begin
            io_rdata = rx_empty ? '1 : DataBitWidth'(rx_head);
        end else if (hit_status) begin
            io_rdata[0]     = !rx_empty;
            io_rdata[1]     = tx_full;
            io_rdata[2]     = tx_idle;
            io_rdata[3]     = overrun_q;
            io_rdata[15:8]  = 8'(rx_count);
            io_rdata[23:16] = 8'(tx_count);
        end
    end

    // Misaligned halfwords (lane 1/3) are dropped: no write strobes, read data zero.
    always_comb begin
        cache_write_enable = 4'b0000;
        cache_data_in      = data_in;
        unique case (write_type)
            2'b01: begin
                cache_write_enable = 4'b0001 << lane;
                cache_data_in      = {24'h0, data_in[7:0]} << {lane, 3'b000};
            end
            2'b10: begin
                cache_write_enable = lane[0] ? 4'b0000 : (lane[1] ? 4'b1100 : 4'b0011);
                cache_data_in      = {16'h0, data_in[15:0]} << {lane[1], 4'b0000};
            end
            2'b11: cache_write_enable = 4'b1111;
            default: cache_write_enable = 4'b0000;
        endcase
        if (io_hit) cache_write_enable = 4'b0000;
    end

    always_comb begin
        lane_data   = cache_data_out >> {lane, 3'b000};
        cache_rdata = '0;
        unique case (read_type[1:0])
            2'b01: cache_rdata = {{24{read_type[2] & lane_data[7]}}, lane_data[7:0]};
            2'b10: cache_rdata = lane[0] ? '0 : {{16{read_type[2] & lane_data[15]}}, lane_data[15:0]};
            2'b11: cache_rdata = cache_data_out;
            default: cache_rdata = '0;
        endcase
    end

    assign data_out       = !enable ? '0 : (io_hit ? io_rdata : cache_rdata);
    assign data_out_ready = io_hit ? enable : cache_data_out_ready;
    assign busy           = io_hit ? (enable && hit_out && is_write && tx_full) : cache_busy;
    assign cache_enable   = enable && !io_hit;
    assign cache_address  = {address[AddressBitWidth-1:2], 2'b00};
    assign led            = led_q;
endmodule

// File: tb/tb_ramio_fifo.sv
// Directed bench for ramio_fifo: combinational vector table plus UART TX/RX sequences
// against a serial-line monitor and driver running at eight clocks per bit.

module tb_ramio_fifo;
    localparam logic [31:0] ADDR_LED    = 32'hffff_fffc;
    localparam logic [31:0] ADDR_OUT    = 32'hffff_fff8;
    localparam logic [31:0] ADDR_IN     = 32'hffff_fff4;
    localparam logic [31:0] ADDR_STATUS = 32'hffff_fff0;
    localparam int          BIT_CYC     = 8;

    logic        clk, rst, enable;
    logic [2:0]  read_type;
    logic [1:0]  write_type;
    logic [31:0] address, data_in, data_out;
    logic        data_out_ready, busy;
    logic [5:0]  led;
    logic        uart_tx, uart_rx;
    logic        cache_enable;
    logic [31:0] cache_address, cache_data_in, cache_data_out;
    logic [3:0]  cache_write_enable;
    logic        cache_data_out_ready, cache_busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] tx_seen[$];
    logic [7:0] mon_byte;

    ramio_fifo #(.ClockFrequencyHz(80), .BaudRate(10)) dut (
        .clk(clk), .rst(rst), .enable(enable), .read_type(read_type), .write_type(write_type),
        .address(address), .data_in(data_in), .data_out(data_out),
        .data_out_ready(data_out_ready), .busy(busy), .led(led),
        .uart_tx(uart_tx), .uart_rx(uart_rx),
        .cache_enable(cache_enable), .cache_address(cache_address),
        .cache_data_in(cache_data_in), .cache_write_enable(cache_write_enable),
        .cache_data_out(cache_data_out), .cache_data_out_ready(cache_data_out_ready),
        .cache_busy(cache_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  rt;
        logic [1:0]  wt;
        logic [31:0] addr, din, cdo;
        logic        crdy, cbsy;
        logic [31:0] e_dout;
        logic        e_rdy, e_bsy, e_cen;
        logic [3:0]  e_we;
        logic [31:0] e_cdin, e_caddr;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cpu_idle();
        enable = 1'b0; read_type = 3'b000; write_type = 2'b00;
        address = 32'h0; data_in = 32'h0;
        cache_data_out = 32'h0; cache_data_out_ready = 1'b0; cache_busy = 1'b0;
    endtask

    task automatic io_read(input logic [31:0] addr, output logic [31:0] val);
        @(negedge clk);
        enable = 1'b1; read_type = 3'b011; write_type = 2'b00; address = addr;
        #1 val = data_out;
        @(posedge clk);
        #1 cpu_idle();
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [31:0] val, output int stall);
        @(negedge clk);
        enable = 1'b1; read_type = 3'b000; write_type = 2'b11; address = addr; data_in = val;
        #1 stall = 0;
        while (busy && stall < 400) begin
            stall++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 cpu_idle();
    endtask

    task automatic uart_send(input logic [7:0] b);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (BIT_CYC + 2) @(negedge clk);
    endtask

    task automatic wait_tx_bytes(input int n, input int budget);
        for (int c = 0; c < budget && tx_seen.size() < n; c++) @(posedge clk);
        check("tx frame count", tx_seen.size(), n);
    endtask

    task automatic wait_tx_idle(input string name);
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            io_read(ADDR_STATUS, v);
            n++;
        end while (!v[2] && n < 500);
        check(name, {31'h0, v[2]}, 32'h1);
    endtask

    // Serial monitor: detect start bit, sample each bit at its centre.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                repeat (BIT_CYC / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    mon_byte[i] = uart_tx;
                end
                repeat (BIT_CYC) @(negedge clk);
                tx_seen.push_back(mon_byte);
            end
        end
    end

    initial begin
        logic [31:0] v;
        int stall;

        vecs[0]  = '{1'b0, 3'b011, 2'b00, 32'h100, 32'h0, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h100};
        vecs[1]  = '{1'b1, 3'b011, 2'b00, 32'h104, 32'h0, 32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h104};
        vecs[2]  = '{1'b1, 3'b001, 2'b00, 32'h102, 32'h0, 32'h00AB0000, 1'b1, 1'b0, 32'h000000AB, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h100};
        vecs[3]  = '{1'b1, 3'b101, 2'b00, 32'h102, 32'h0, 32'h00AB0000, 1'b1, 1'b0, 32'hFFFFFFAB, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h100};
        vecs[4]  = '{1'b1, 3'b000, 2'b01, 32'h102, 32'hAB, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h00AB0000, 32'h100};
        vecs[5]  = '{1'b1, 3'b000, 2'b10, 32'h102, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h12340000, 32'h100};
        vecs[6]  = '{1'b1, 3'b000, 2'b10, 32'h101, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h00001234, 32'h100};
        vecs[7]  = '{1'b1, 3'b110, 2'b00, 32'h100, 32'h0, 32'h00008001, 1'b1, 1'b0, 32'hFFFF8001, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h100};
        vecs[8]  = '{1'b1, 3'b010, 2'b00, 32'h102, 32'h0, 32'h80010000, 1'b1, 1'b0, 32'h00008001, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h100};
        vecs[9]  = '{1'b1, 3'b110, 2'b00, 32'h103, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h100};
        vecs[10] = '{1'b1, 3'b000, 2'b11, 32'h10b, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h108};
        vecs[11] = '{1'b1, 3'b101, 2'b00, 32'h107, 32'h0, 32'h80000000, 1'b1, 1'b0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h104};
        vecs[12] = '{1'b1, 3'b011, 2'b00, ADDR_IN, 32'h0, 32'h5555, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, ADDR_IN};
        vecs[13] = '{1'b1, 3'b011, 2'b00, ADDR_STATUS, 32'h0, 32'h0, 1'b0, 1'b0, 32'h00000004, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, ADDR_STATUS};
        vecs[14] = '{1'b1, 3'b011, 2'b00, ADDR_OUT, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, ADDR_OUT};
        vecs[15] = '{1'b1, 3'b011, 2'b00, ADDR_LED, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000003F, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, ADDR_LED};

        cpu_idle();
        uart_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset led", {26'h0, led}, 32'h3F);
        check("reset uart_tx", {31'h0, uart_tx}, 32'h1);
        check("reset data_out idle", data_out, 32'h0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            enable = vecs[i].en; read_type = vecs[i].rt; write_type = vecs[i].wt;
            address = vecs[i].addr; data_in = vecs[i].din; cache_data_out = vecs[i].cdo;
            cache_data_out_ready = vecs[i].crdy; cache_busy = vecs[i].cbsy;
            #1;
            $display("vec %0d addr=%08h rt=%b wt=%b dout=%08h we=%b cdin=%08h",
                     i, vecs[i].addr, vecs[i].rt, vecs[i].wt, data_out, cache_write_enable, cache_data_in);
            check($sformatf("vec%0d data_out", i), data_out, vecs[i].e_dout);
            check($sformatf("vec%0d ready", i), {31'h0, data_out_ready}, {31'h0, vecs[i].e_rdy});
            check($sformatf("vec%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].e_bsy});
            check($sformatf("vec%0d cache_en", i), {31'h0, cache_enable}, {31'h0, vecs[i].e_cen});
            check($sformatf("vec%0d we", i), {28'h0, cache_write_enable}, {28'h0, vecs[i].e_we});
            check($sformatf("vec%0d cdin", i), cache_data_in, vecs[i].e_cdin);
            check($sformatf("vec%0d caddr", i), cache_address, vecs[i].e_caddr);
        end
        @(posedge clk);
        #1 cpu_idle();

        io_write(ADDR_LED, 32'h15, stall);
        @(negedge clk);
        $display("led write 0x15 -> led=%b", led);
        check("led write", {26'h0, led}, 32'h15);

        tx_seen.delete();
        for (int i = 0; i < 3; i++) begin
            io_write(ADDR_OUT, 32'h41 + i, stall);
            $display("tx write 0x%02h stall=%0d", 8'h41 + i, stall);
            check($sformatf("tx3 write %0d no busy", i), stall, 0);
        end
        wait_tx_bytes(3, 1000);
        for (int i = 0; i < 3 && i < tx_seen.size(); i++) begin
            $display("tx frame %0d = 0x%02h", i, tx_seen[i]);
            check($sformatf("tx3 byte %0d", i), {24'h0, tx_seen[i]}, 32'h41 + i);
        end
        wait_tx_idle("tx3 idle bit");

        tx_seen.delete();
        for (int i = 0; i < 17; i++) begin
            io_write(ADDR_OUT, 32'h60 + i, stall);
            check($sformatf("tx18 write %0d no busy", i), stall, 0);
        end
        io_read(ADDR_STATUS, v);
        $display("status with tx full = 0x%08h", v);
        check("tx full status", v, 32'h0010_0002);
        io_write(ADDR_OUT, 32'h71, stall);
        $display("tx write 0x71 stall=%0d", stall);
        check("tx18 stall then accept", {31'h0, (stall > 0 && stall < 400)}, 32'h1);
        wait_tx_bytes(18, 4000);
        for (int i = 0; i < 18 && i < tx_seen.size(); i++) begin
            check($sformatf("tx18 byte %0d", i), {24'h0, tx_seen[i]}, 32'h60 + i);
        end
        $display("tx18 frames received = %0d", tx_seen.size());
        wait_tx_idle("tx18 idle bit");

        for (int i = 0; i < 17; i++) uart_send(8'hA0 + 8'(i));
        repeat (5) @(posedge clk);
        io_read(ADDR_STATUS, v);
        $display("status after 17 rx bytes = 0x%08h", v);
        check("rx overrun status", v, 32'h0000_100D);
        for (int i = 0; i < 16; i++) begin
            io_read(ADDR_IN, v);
            $display("rx read %0d = 0x%08h", i, v);
            check($sformatf("rx byte %0d", i), v, 32'hA0 + i);
        end
        io_read(ADDR_IN, v);
        check("rx empty read", v, 32'hFFFF_FFFF);
        io_read(ADDR_STATUS, v);
        $display("status after drain = 0x%08h", v);
        check("overrun cleared", v, 32'h0000_0004);

        tx_seen.delete();
        for (int i = 0; i < 3; i++) io_write(ADDR_OUT, 32'h00, stall);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("uart_tx mid frame", {31'h0, uart_tx}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("uart_tx after reset", {31'h0, uart_tx}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-transfer applied");
        check("led after reset", {26'h0, led}, 32'h3F);
        io_read(ADDR_STATUS, v);
        check("status after reset", v, 32'h0000_0004);
        io_read(ADDR_OUT, v);
        check("uartout after reset", v, 32'hFFFF_FFFF);
        repeat (100) @(posedge clk);
        tx_seen.delete();
        repeat (150) @(posedge clk);
        check("no frames after reset", tx_seen.size(), 0);
        check("line idle after reset", {31'h0, uart_tx}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
